// File: rtl/it_pkg.sv
// ============================================================================
//  Package : it_pkg
//  Brief   : Shared types and tile geometry for the It derivative path
//            (window loader and It stage).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package it_pkg;

    // Default inner window side and pixel width.
    localparam int IT_SIDE = 3;
    localparam int IT_DW   = 32;

    // Tile geometry: the inner window plus a one-pixel border on every side.
    localparam int TILE_W = IT_SIDE + 2;
    localparam int TILE_N = TILE_W * TILE_W;

    typedef logic [IT_DW-1:0] pix_t;

    typedef struct packed {
        pix_t cur;
        pix_t nxt;
    } pix_pair_t;

    // Width of an index into an n-entry array; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/it_window_bank.sv
// ============================================================================
//  Module  : it_window_bank
//  Brief   : N-entry (current, next) pixel pair register file with a single
//            write port, fully parallel read-out and a tile-full flag.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module it_window_bank
    import it_pkg::*;
#(
    parameter int DW = IT_DW,
    parameter int N  = TILE_N
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [idx_w(N)-1:0]   waddr_i,
    input  logic [DW-1:0]         wcur_i,
    input  logic [DW-1:0]         wnxt_i,
    input  logic                  set_full_i,
    input  logic                  clr_full_i,
    output logic                  full_o,
    output logic [DW-1:0]         cur_o [N],
    output logic [DW-1:0]         nxt_o [N]
);

    logic [DW-1:0] cur_q [N];
    logic [DW-1:0] nxt_q [N];
    logic          full_q;

    // Pair storage and full flag; the owner never sets and clears in one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                cur_q[i] <= '0;
                nxt_q[i] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            if (we_i) begin
                cur_q[waddr_i] <= wcur_i;
                nxt_q[waddr_i] <= wnxt_i;
            end
            if (set_full_i) begin
                full_q <= 1'b1;
            end else if (clr_full_i) begin
                full_q <= 1'b0;
            end
        end
    end

    // Expose the whole tile in parallel.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cur_o[i] = cur_q[i];
            nxt_o[i] = nxt_q[i];
        end
        full_o = full_q;
    end

endmodule

`default_nettype wire

// File: rtl/it_window_loader.sv
// ============================================================================
//  Module  : it_window_loader
//  Brief   : Ping-pong tile gatherer feeding the It stage. Collects a raster
//            stream of (current, next) pixel pairs into (SIDE+2)^2 tiles and
//            presents one full tile downstream while the other bank fills.
//  Macro   : IT_WINDOW_LOADER_TILE_CNT_EN - adds the tile_cnt output, a
//            wrapping count of completed output handshakes.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module it_window_loader
    import it_pkg::*;
#(
    parameter int SIDE = IT_SIDE,
    parameter int DW   = IT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_val,
    output logic          in_rdy,
    input  logic [DW-1:0] in_cur,
    input  logic [DW-1:0] in_nxt,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [DW-1:0] out_cur [(SIDE+2)*(SIDE+2)],
    output logic [DW-1:0] out_nxt [(SIDE+2)*(SIDE+2)]
`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
    ,
    output logic [31:0]   tile_cnt
`endif
);

    localparam int W  = SIDE + 2;
    localparam int N  = W * W;
    localparam int AW = idx_w(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] idx_q,   idx_d;

    logic [1:0]    bank_full;
    logic [DW-1:0] bank_cur [2][N];
    logic [DW-1:0] bank_nxt [2][N];

    logic          in_fire;
    logic          out_fire;
    logic          idx_last;

    // Handshake status depends only on the registered full flags and pointers.
    always_comb begin
        in_rdy   = !bank_full[wbank_q];
        out_val  = bank_full[rbank_q];
        in_fire  = in_val && in_rdy;
        out_fire = out_rdy && out_val;
        idx_last = (idx_q == LAST_IDX);
    end

    // Next pointer/index values: the write side advances per pair and flips
    // banks on the last pair; the read side flips banks on every drain.
    always_comb begin
        idx_d   = idx_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        if (in_fire) begin
            if (idx_last) begin
                idx_d   = '0;
                wbank_d = !wbank_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (out_fire) begin
            rbank_d = !rbank_q;
        end
    end

    // Pointer and index registers; reset discards any partial or unsent tile.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q   <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
        end
    end

    // Two banks: an accept targets wbank, a drain targets rbank. Since accept
    // needs the bank empty and drain needs it full, both can fire at once only
    // on different banks.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic bank_we;
        logic bank_set;
        logic bank_clr;

        assign bank_we  = in_fire  && (wbank_q == 1'(b));
        assign bank_set = bank_we  && idx_last;
        assign bank_clr = out_fire && (rbank_q == 1'(b));

        it_window_bank #(
            .DW (DW),
            .N  (N)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .we_i       (bank_we),
            .waddr_i    (idx_q),
            .wcur_i     (in_cur),
            .wnxt_i     (in_nxt),
            .set_full_i (bank_set),
            .clr_full_i (bank_clr),
            .full_o     (bank_full[b]),
            .cur_o      (bank_cur[b]),
            .nxt_o      (bank_nxt[b])
        );
    end

    // The read bank always drives the tile outputs.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_cur[i] = rbank_q ? bank_cur[1][i] : bank_cur[0][i];
            out_nxt[i] = rbank_q ? bank_nxt[1][i] : bank_nxt[0][i];
        end
    end

`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
    logic [31:0] tile_cnt_q;

    // Completed output handshakes, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tile_cnt_q <= '0;
        end else if (out_fire) begin
            tile_cnt_q <= tile_cnt_q + 32'd1;
        end
    end

    assign tile_cnt = tile_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_it_window_loader.sv
// ============================================================================
//  Module  : tb_it_window_loader
//  Brief   : Directed self-checking bench for it_window_loader (SIDE=3, N=25).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_it_window_loader;

    localparam int DW = 32;
    localparam int N  = 25;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_cur = '0;
    logic [DW-1:0] in_nxt = '0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_cur [N];
    logic [DW-1:0] out_nxt [N];
`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
    logic [31:0]   tile_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    it_window_loader #(
        .SIDE (3),
        .DW   (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_cur   (in_cur),
        .in_nxt   (in_nxt),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_cur  (out_cur),
        .out_nxt  (out_nxt)
`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
        ,
        .tile_cnt (tile_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int nz;
        reset   = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        n_vec++;
        if (in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
        end
        n_vec++;
        if (out_val !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_val: got %b want 0", out_val);
        end
        nz = 0;
        for (int i = 0; i < N; i++) begin
            if (out_cur[i] !== '0 || out_nxt[i] !== '0) nz++;
        end
        n_vec++;
        if (nz !== 0) begin
            n_err++;
            $display("FAIL reset_outputs_zero: %0d nonzero entries, want 0", nz);
        end
`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
        n_vec++;
        if (tile_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_tile_cnt: got %0d want 0", tile_cnt);
        end
`endif
    endtask

    // First tile: cur=k, nxt=100+k with downstream stalled.
    task automatic test_fill();
        out_rdy = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_val = 1'b1;
            in_cur = DW'(k);
            in_nxt = DW'(100 + k);
            n_vec++;
            if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
                n_err++;
                $display("FAIL fill_pre_k%0d: in_rdy=%b out_val=%b want 1/0", k, in_rdy, out_val);
            end
            tick();
        end
        in_val = 1'b0;
        n_vec++;
        if (out_val !== 1'b1) begin
            n_err++;
            $display("FAIL fill_out_val: got %b want 1", out_val);
        end
        n_vec++;
        if (out_cur[12] !== 32'd12 || out_nxt[12] !== 32'd112) begin
            n_err++;
            $display("FAIL fill_center: cur=%0d nxt=%0d want 12/112", out_cur[12], out_nxt[12]);
        end
        n_vec++;
        if (out_cur[0] !== 32'd0 || out_nxt[24] !== 32'd124) begin
            n_err++;
            $display("FAIL fill_corners: cur0=%0d nxt24=%0d want 0/124", out_cur[0], out_nxt[24]);
        end
    endtask

    // Second tile fills while the first is held; then both banks are full.
    task automatic test_backpressure();
        out_rdy = 1'b0;
        for (int k = 25; k < 50; k++) begin
            in_val = 1'b1;
            in_cur = DW'(k);
            in_nxt = DW'(100 + k);
            n_vec++;
            if (in_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_accept_k%0d: in_rdy=%b want 1", k, in_rdy);
            end
            tick();
        end
        // Pair 50 is offered but must be held off.
        in_cur = 32'd50;
        in_nxt = 32'd150;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (in_rdy !== 1'b0 || out_val !== 1'b1 || out_cur[0] !== 32'd0 || out_cur[24] !== 32'd24) begin
                n_err++;
                $display("FAIL bp_hold_c%0d: in_rdy=%b out_val=%b cur0=%0d cur24=%0d want 0/1/0/24",
                         c, in_rdy, out_val, out_cur[0], out_cur[24]);
            end
            tick();
        end
    endtask

    // One-cycle drain swaps in tile 2 and frees a bank.
    task automatic test_drain();
        in_val  = 1'b0;
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        n_vec++;
        if (out_cur[0] !== 32'd25 || out_nxt[0] !== 32'd125 || out_cur[24] !== 32'd49) begin
            n_err++;
            $display("FAIL drain_tile2: cur0=%0d nxt0=%0d cur24=%0d want 25/125/49",
                     out_cur[0], out_nxt[0], out_cur[24]);
        end
        n_vec++;
        if (in_rdy !== 1'b1 || out_val !== 1'b1) begin
            n_err++;
            $display("FAIL drain_flags: in_rdy=%b out_val=%b want 1/1", in_rdy, out_val);
        end
`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
        n_vec++;
        if (tile_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL drain_tile_cnt: got %0d want 1", tile_cnt);
        end
`endif
    endtask

    // 100 pairs streamed with both sides open; one extra edge drains the last tile.
    task automatic test_back_to_back();
        int hs_cnt;
        int last_edge;
        int drops;
        hs_cnt    = 0;
        last_edge = 0;
        drops     = 0;
        out_rdy   = 1'b1;
        for (int e = 0; e <= 100; e++) begin
            in_val = (e < 100);
            in_cur = DW'(1000 + e);
            in_nxt = DW'(2000 + e);
            if (e < 100 && in_rdy !== 1'b1) drops++;
            if (out_val === 1'b1) begin
                if (hs_cnt == 0) begin
                    n_vec++;
                    if (e !== 0 || out_cur[0] !== 32'd25) begin
                        n_err++;
                        $display("FAIL b2b_old_tile: edge=%0d cur0=%0d want 0/25", e, out_cur[0]);
                    end
                end else begin
                    n_vec++;
                    if (e - last_edge !== 25) begin
                        n_err++;
                        $display("FAIL b2b_spacing_t%0d: gap=%0d want 25", hs_cnt, e - last_edge);
                    end
                    n_vec++;
                    if (out_cur[0] !== DW'(1000 + 25 * (hs_cnt - 1)) ||
                        out_nxt[24] !== DW'(2024 + 25 * (hs_cnt - 1))) begin
                        n_err++;
                        $display("FAIL b2b_data_t%0d: cur0=%0d nxt24=%0d want %0d/%0d", hs_cnt,
                                 out_cur[0], out_nxt[24], 1000 + 25 * (hs_cnt - 1),
                                 2024 + 25 * (hs_cnt - 1));
                    end
                end
                hs_cnt++;
                last_edge = e;
            end
            tick();
        end
        in_val  = 1'b0;
        out_rdy = 1'b0;
        n_vec++;
        if (hs_cnt !== 5) begin
            n_err++;
            $display("FAIL b2b_tile_count: got %0d handshakes want 5", hs_cnt);
        end
        n_vec++;
        if (drops !== 0) begin
            n_err++;
            $display("FAIL b2b_in_rdy_drop: %0d drops want 0", drops);
        end
        n_vec++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle: out_val=%b in_rdy=%b want 0/1", out_val, in_rdy);
        end
`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
        n_vec++;
        if (tile_cnt !== 32'd6) begin
            n_err++;
            $display("FAIL b2b_tile_cnt: got %0d want 6", tile_cnt);
        end
`endif
    endtask

    // Reset after 10 pairs discards the partial tile; a fresh tile lands at index 0.
    task automatic test_reset_mid();
        out_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_val = 1'b1;
            in_cur = DW'(500 + k);
            in_nxt = DW'(550 + k);
            tick();
        end
        reset   = 1'b0;
        out_rdy = 1'b1;
        tick();
        reset   = 1'b1;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        n_vec++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1 || out_cur[0] !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_state: out_val=%b in_rdy=%b cur0=%0d want 0/1/0",
                     out_val, in_rdy, out_cur[0]);
        end
`ifdef IT_WINDOW_LOADER_TILE_CNT_EN
        n_vec++;
        if (tile_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_tile_cnt: got %0d want 0", tile_cnt);
        end
`endif
        for (int k = 0; k < N; k++) begin
            in_val = 1'b1;
            in_cur = DW'(600 + k);
            in_nxt = DW'(700 + k);
            tick();
        end
        in_val = 1'b0;
        n_vec++;
        if (out_val !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_out_val: got %b want 1", out_val);
        end
        n_vec++;
        if (out_cur[0] !== 32'd600 || out_cur[10] !== 32'd610 || out_nxt[24] !== 32'd724) begin
            n_err++;
            $display("FAIL rstmid_tile: cur0=%0d cur10=%0d nxt24=%0d want 600/610/724",
                     out_cur[0], out_cur[10], out_nxt[24]);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
